// File: rtl/filter_ctrl_pkg.sv
// filter_ctrl_pkg
// Shared definitions for the SID filter register controller:
//   - bus address map of the four filter registers
//   - sequencer state encoding
//   - field widths of the committed filter parameters
package filter_ctrl_pkg;

    localparam int FC_W  = 11;
    localparam int NIB_W = 4;

    localparam logic [1:0] ADDR_FC_LO    = 2'd0;
    localparam logic [1:0] ADDR_FC_HI    = 2'd1;
    localparam logic [1:0] ADDR_RES_FILT = 2'd2;
    localparam logic [1:0] ADDR_MODE_VOL = 2'd3;

    typedef enum logic [1:0] {
        COUNT  = 2'd0,
        COMMIT = 2'd1,
        STROBE = 2'd2
    } state_t;

endpackage

// File: rtl/filter_slew.sv
// filter_slew
// Step limiter: on each enabled clock, moves cur toward target by at most
// STEP. Never overshoots, so cur always stays within 0..2^W-1.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (cur -> 0)
//   en         apply one step this cycle
//   target     value to approach
//   cur        current (committed) value
module filter_slew #(
    parameter int W    = 11,
    parameter int STEP = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] target,
    output logic [W-1:0] cur
);

    // A step at least as large as the full range means "jump straight there".
    localparam int            STEP_SAT = (STEP > (1 << W) - 1) ? (1 << W) - 1 : STEP;
    localparam logic [W-1:0]  STEP_C   = W'(STEP_SAT);

    logic [W-1:0] diff;
    logic [W-1:0] delta;
    logic [W-1:0] nxt;

    always_comb begin
        diff  = '0;
        delta = '0;
        nxt   = cur;
        if (target >= cur) begin
            diff  = target - cur;
            delta = (diff > STEP_C) ? STEP_C : diff;
            nxt   = cur + delta;
        end else begin
            diff  = cur - target;
            delta = (diff > STEP_C) ? STEP_C : diff;
            nxt   = cur - delta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= '0;
        end else if (en) begin
            cur <= nxt;
        end
    end

endmodule

// File: rtl/filter_ctrl.sv
// filter_ctrl
// Register interface and sample sequencer for the SID filter. Bus writes
// land in shadow registers; all shadows are committed together once per
// audio sample, with fc and vol slew-limited. A one-cycle sample_valid
// strobe follows each commit.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   run             1 = sequencer counts, 0 = hold
//   wr_valid/ready  bus write handshake, wr_addr/wr_data carry the write
//   fc,res,filt,    committed filter parameters
//   mode,vol
//   sample_valid    one-cycle strobe per audio sample
//   pending         shadow state differs from committed state
//
// state  | meaning
// COUNT  | divider running (or held while run=0), writes accepted
// COMMIT | shadows -> outputs, fc/vol take one slew step, writes stalled
// STROBE | sample_valid high, writes accepted
module filter_ctrl
    import filter_ctrl_pkg::*;
#(
    parameter int SAMPLE_DIV = 500,
    parameter int FC_STEP    = 32,
    parameter int VOL_STEP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [1:0]       wr_addr,
    input  logic [7:0]       wr_data,
    output logic [FC_W-1:0]  fc,
    output logic [NIB_W-1:0] res,
    output logic [NIB_W-1:0] filt,
    output logic [NIB_W-1:0] mode,
    output logic [NIB_W-1:0] vol,
    output logic             sample_valid,
    output logic             pending
);

    localparam int              CNT_W    = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 2);

    state_t             state;
    logic [CNT_W-1:0]   cnt;

    logic [FC_W-1:0]    sh_fc;
    logic [NIB_W-1:0]   sh_res;
    logic [NIB_W-1:0]   sh_filt;
    logic [NIB_W-1:0]   sh_mode;
    logic [NIB_W-1:0]   sh_vol;

    logic               wr_fire;
    logic               commit_en;

    assign wr_fire   = wr_valid & wr_ready;
    assign commit_en = (state == COMMIT);

    // Shadow registers, SID register layout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_fc   <= '0;
            sh_res  <= '0;
            sh_filt <= '0;
            sh_mode <= '0;
            sh_vol  <= '0;
        end else if (wr_fire) begin
            case (wr_addr)
                ADDR_FC_LO:    sh_fc[2:0]  <= wr_data[2:0];
                ADDR_FC_HI:    sh_fc[10:3] <= wr_data;
                ADDR_RES_FILT: begin
                    sh_res  <= wr_data[7:4];
                    sh_filt <= wr_data[3:0];
                end
                ADDR_MODE_VOL: begin
                    sh_mode <= wr_data[7:4];
                    sh_vol  <= wr_data[3:0];
                end
                default: ;
            endcase
        end
    end

    // Sequencer. COUNT spans SAMPLE_DIV-2 cycles per period so that, with
    // COMMIT and STROBE, the strobe period is exactly SAMPLE_DIV.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= COUNT;
            cnt          <= '0;
            sample_valid <= 1'b0;
            wr_ready     <= 1'b0;
            res          <= '0;
            filt         <= '0;
            mode         <= '0;
        end else begin
            sample_valid <= 1'b0;
            wr_ready     <= 1'b1;
            case (state)
                COUNT: begin
                    if (run) begin
                        if (cnt == CNT_LAST) begin
                            cnt      <= '0;
                            state    <= COMMIT;
                            wr_ready <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    res          <= sh_res;
                    filt         <= sh_filt;
                    mode         <= sh_mode;
                    sample_valid <= 1'b1;
                    state        <= STROBE;
                end
                STROBE: begin
                    // The strobe cycle is the first cycle of the next period.
                    cnt   <= CNT_W'(1);
                    state <= COUNT;
                end
                default: begin
                    cnt   <= '0;
                    state <= COUNT;
                end
            endcase
        end
    end

    filter_slew #(.W(FC_W), .STEP(FC_STEP)) u_fc_slew (
        .clk    (clk),
        .rst    (rst),
        .en     (commit_en),
        .target (sh_fc),
        .cur    (fc)
    );

    filter_slew #(.W(NIB_W), .STEP(VOL_STEP)) u_vol_slew (
        .clk    (clk),
        .rst    (rst),
        .en     (commit_en),
        .target (sh_vol),
        .cur    (vol)
    );

    assign pending = (sh_fc != fc) | (sh_vol != vol) | (sh_res != res)
                   | (sh_filt != filt) | (sh_mode != mode);

endmodule
